pipeline_ctrl: RTL

Hazard and pipeline-sequencing controller for the 5-stage RISC-V core. It drives the enable (stall) and clear (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, whose synchronous clear zeroes a stage into a bubble. It also generates the EX-stage forwarding selects and holds the whole pipeline during multi-cycle data-memory accesses, with a watchdog on memory waits.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 35 +++
 rtl/fwd_unit.sv | 22 ++
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select encoding and register-index width.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Core <-> hazard controller signal bundle. The core datapath is the master
// (drives register indices and memory handshake), the controller is the slave
// (returns stall/flush/forward controls and the fault flag).
interface pipeline_ctrl_if;
  import pipe_ctrl_pkg::*;

  reg_idx_t rs1_d, rs2_d;
  reg_idx_t rs1_e, rs2_e, rd_e;
  logic     load_e;
  logic     pc_src_e;
  reg_idx_t rd_m, rd_w;
  logic     reg_write_m, reg_write_w;
  logic     dmem_req_m;
  logic     dmem_ready;

  logic     stall_f, stall_d, stall_e, stall_m;
  logic     flush_d, flush_e, flush_w;
  fwd_sel_t fwd_a_e, fwd_b_e;
  logic     mem_fault;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
           rd_m, rd_w, reg_write_m, reg_write_w, dmem_req_m, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, mem_fault
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
           rd_m, rd_w, reg_write_m, reg_write_w, dmem_req_m, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, mem_fault
  );

endinterface

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one source operand. MEM result is newer
// than WB, so it wins when both stages target the same register; x0 is
// never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  reg_idx_t rs_e,
  input  reg_idx_t rd_m,
  input  reg_idx_t rd_w,
  input  logic     reg_write_m,
  input  logic     reg_write_w,
  output fwd_sel_t sel
);

  // Priority select: MEM, then WB, else register file
  always_comb begin
    sel = FWD_RF;
    if (rs_e != '0 && reg_write_m && rd_m == rs_e)      sel = FWD_MEM;
    else if (rs_e != '0 && reg_write_w && rd_w == rs_e) sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard / sequencing controller for the 5-stage core: stall and flush
// generation, EX forwarding selects, and a watchdog on data-memory waits.
// Optional feature macro: PERF_CNT_EN adds stall_cycles / flush_events
// performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   pif
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int NUM_OPS = 2;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             fault_q;

  logic mem_stall, branch, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  // ---------------- forwarding (state independent) ----------------
  logic [NUM_OPS-1:0][REG_W-1:0] rs_e;
  fwd_sel_t [NUM_OPS-1:0]        fwd;

  assign rs_e = {pif.rs2_e, pif.rs1_e};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    fwd_unit u_fwd (
      .rs_e        (rs_e[i]),
      .rd_m        (pif.rd_m),
      .rd_w        (pif.rd_w),
      .reg_write_m (pif.reg_write_m),
      .reg_write_w (pif.reg_write_w),
      .sel         (fwd[i])
    );
  end

  // ---------------- hazard conditions ----------------
  // A branch seen while memory stalls is simply held in EX; since pc_src_e
  // stays high it re-fires in the first unstalled cycle, so no deferral
  // state is needed.
  assign mem_stall = pif.dmem_req_m && !pif.dmem_ready &&
                     (state == RUN || state == MEM_WAIT);
  assign branch    = pif.pc_src_e && !mem_stall;
  assign load_use  = pif.load_e && pif.rd_e != '0 &&
                     (pif.rd_e == pif.rs1_d || pif.rd_e == pif.rs2_d) &&
                     !mem_stall && !branch;

  // State/counter/fault registers; reset is synchronous
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      fault_q  <= (state_nxt == FAULT);
    end
  end

  // Next-state, wait counter and stall/flush outputs
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall)                            state_nxt = RUN;
        else if (wait_cnt >= CNT_W'(MEM_TIMEOUT))  state_nxt = FAULT;
        else                                       wait_cnt_nxt = wait_cnt + CNT_W'(1);
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase

    // Outputs are forced quiet while reset is held
    if (!reset) begin
      if (state == FAULT || mem_stall) begin
        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
      end else if (branch) begin
        {flush_d, flush_e} = 2'b11;
      end else if (load_use) begin
        {stall_f, stall_d, flush_e} = 3'b111;
      end
    end
  end

  assign pif.stall_f   = stall_f;
  assign pif.stall_d   = stall_d;
  assign pif.stall_e   = stall_e;
  assign pif.stall_m   = stall_m;
  assign pif.flush_d   = flush_d;
  assign pif.flush_e   = flush_e;
  assign pif.flush_w   = flush_w;
  assign pif.fwd_a_e   = reset ? FWD_RF : fwd[0];
  assign pif.fwd_b_e   = reset ? FWD_RF : fwd[1];
  assign pif.mem_fault = fault_q && !reset;

`ifdef PERF_CNT_EN
  // Performance counters: stalled fetch cycles and front-end flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_f)            stall_cycles <= stall_cycles + 32'd1;
      if (flush_d || flush_e) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
